ram_sp_march_bist: RTL and testbench

Built-in self-test engine for the single-port synchronous RAM. It sits on the RAM's port in place of the functional master. It drives address, write data, write enable and output enable, and checks the registered read data against a March C- sequence. After a start pulse it runs the full march once and reports pass or fail.

---
 rtl/ram_sp_march_bist.sv | 225 ++++++++++++++++++++++
 tb/tb_ram_sp_march_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_march_bist.sv
// ram_sp_march_bist
//
// Built-in self-test engine for a single-port synchronous RAM. It takes the
// place of the functional master on the RAM port. A start pulse runs one
// full March C- pass, and the engine then reports pass or fail. The six
// elements are:
//
//     up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
//
// Each element does all of its operations at one address before it moves
// to the next address. Every read is checked one cycle later against the
// RAM's registered read data.
//
// Parameters:
//     DATA_WIDTH  RAM word width
//     ADDR_WIDTH  RAM address width; the depth is 1 << ADDR_WIDTH
//
// Ports:
//     clk        clock; all logic is clocked on the rising edge
//     rst        asynchronous active-high reset
//     start      one-cycle run request; accepted only in IDLE or DONE
//     busy       high while a march runs, including the final drain cycle
//     done       level; set at the end of a run, cleared by an accepted start
//     fail       sticky mismatch flag, cleared by an accepted start
//     ram_addr   RAM address
//     ram_din    RAM write data
//     ram_we     RAM write enable
//     ram_oe     RAM output enable; never high together with ram_we
//     ram_dout   RAM registered read data
//
// Optional feature macro: BIST_FAIL_LOG_EN
//     When this macro is defined, the ports fail_addr, fail_exp and fail_act
//     are added. They hold the address, the expected word and the actual
//     word of the first mismatch in the current run.

module ram_sp_march_bist #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef BIST_FAIL_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_q, op_d;
    logic                  fail_q, fail_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;

    logic in_run;
    logic elem_down;
    logic single_op;
    logic op_write;
    logic wr_one;
    logic rd_one;
    logic last_addr;
    logic mismatch;
    logic start_ok;

    // Decode the current element and operation.
    // E0 and E5 have a single operation. E1 to E4 read at op 0 and write
    // at op 1.
    always_comb begin
        in_run    = (state_q == S_RUN);
        elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
        single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
        op_write  = (elem_q == 3'd0) || (!single_op && op_q);
        wr_one    = (elem_q == 3'd1) || (elem_q == 3'd3);
        rd_one    = (elem_q == 3'd2) || (elem_q == 3'd4);
        last_addr = elem_down ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_LAST);
        mismatch  = cmp_valid_q && (ram_dout != exp_q);
        start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Sequencer.
    // When the last address of an element is reached, the counter loads the
    // start address of the next element in the same cycle, so no cycle is
    // lost between elements.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        op_d        = op_q;
        fail_d      = fail_q | mismatch;
        cmp_valid_d = in_run && !op_write;
        exp_d       = {DATA_WIDTH{rd_one}};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    elem_d  = 3'd0;
                    addr_d  = ADDR_ZERO;
                    op_d    = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (!single_op && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (last_addr) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                            addr_d  = ADDR_ZERO;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : ADDR_ZERO;
                        end
                    end else begin
                        addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= ADDR_ZERO;
            op_q        <= 1'b0;
            fail_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            fail_q      <= fail_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
        end
    end

    // The RAM port is decoded directly from state flops. Because of this,
    // an asynchronous reset quiets the port at once.
    always_comb begin
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
        fail     = fail_q;
        ram_addr = in_run ? addr_q : ADDR_ZERO;
        ram_we   = in_run && op_write;
        ram_oe   = in_run && !op_write;
        ram_din  = (in_run && op_write) ? {DATA_WIDTH{wr_one}} : '0;
    end

`ifdef BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_p_q, addr_p_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

    // addr_p follows the compare pipeline, so a mismatch is logged with the
    // address that was read. Only the first mismatch of a run is kept.
    always_comb begin
        addr_p_d    = addr_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        if (start_ok) begin
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_d = addr_p_q;
            fail_exp_d  = exp_q;
            fail_act_d  = ram_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p_q    <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            addr_p_q    <= addr_p_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
`endif

endmodule

// File: tb/tb_ram_sp_march_bist.sv
// tb_ram_sp_march_bist
//
// Testbench for ram_sp_march_bist with a 16 x 4 RAM.
// A behavioural registered-read RAM model sits on the BIST port. The model
// can make bit 0 at address 5 read as stuck at 1.
// Each table entry describes one march run: whether the fault is injected,
// whether a stray start arrives mid-run, and the expected outcome.
// Hand-written sequences cover the reset state, the E3 address order,
// a reset in the middle of a run, and back-to-back clearing.

module tb_ram_sp_march_bist;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_we;
    logic       ram_oe;
    logic [3:0] ram_dout;
`ifdef BIST_FAIL_LOG_EN
    logic [3:0] fail_addr;
    logic [3:0] fail_exp;
    logic [3:0] fail_act;
`endif

    ram_sp_march_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_dout (ram_dout)
`ifdef BIST_FAIL_LOG_EN
        ,
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_act (fail_act)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM model. When fault_en is set, bit 0 at address 5
    // always reads back as 1.
    logic [3:0] mem [16];
    bit         fault_en;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        if (ram_oe)
            ram_dout <= mem[ram_addr] | (((fault_en == 1'b1) && (ram_addr == 4'd5)) ? 4'h1 : 4'h0);
    end

    typedef struct {
        string name;
        bit    fault;
        bit    extra_start;
        int    exp_busy;
        int    exp_we;
        int    exp_oe;
        int    exp_fail;
        int    exp_faddr;
        int    exp_fexp;
        int    exp_fact;
    } vec_t;

    vec_t vecs [4];

    int n_cmp;
    int n_bad;

    int res_busy;
    int res_we;
    int res_oe;
    int res_overlap;
    int res_done0;
    int res_fail0;
    int res_done_end;
    int res_fail_end;
    int res_timeout;

    logic [3:0] tr_addr [200];
    logic       tr_we   [200];
    logic       tr_oe   [200];
    logic [3:0] tr_din  [200];

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then record the run one negedge at a time
    // until busy falls. The number of cycles is bounded. A stray start can
    // be injected 40 cycles into the run.
    task automatic applyStimulus(input bit extra);
        int n;
        res_we      = 0;
        res_oe      = 0;
        res_overlap = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_done0 = int'(done);
        res_fail0 = int'(fail);
        n = 0;
        while (busy && n < 400) begin
            if (n < 200) begin
                tr_addr[n] = ram_addr;
                tr_we[n]   = ram_we;
                tr_oe[n]   = ram_oe;
                tr_din[n]  = ram_din;
            end
            res_we      += int'(ram_we);
            res_oe      += int'(ram_oe);
            res_overlap += int'(ram_we && ram_oe);
            n++;
            start = extra && (n == 40);
            @(negedge clk);
        end
        start        = 1'b0;
        res_busy     = n;
        res_timeout  = (n >= 400) ? 1 : 0;
        res_done_end = int'(done);
        res_fail_end = int'(fail);
    endtask

    task automatic checkRun(input string tag, input vec_t v);
        checkOutput({tag, "_timeout"},    res_timeout,  0);
        checkOutput({tag, "_done_clr"},   res_done0,    0);
        checkOutput({tag, "_fail_clr"},   res_fail0,    0);
        checkOutput({tag, "_busy_len"},   res_busy,     v.exp_busy);
        checkOutput({tag, "_we_count"},   res_we,       v.exp_we);
        checkOutput({tag, "_oe_count"},   res_oe,       v.exp_oe);
        checkOutput({tag, "_we_oe_both"}, res_overlap,  0);
        checkOutput({tag, "_done_end"},   res_done_end, 1);
        checkOutput({tag, "_fail_end"},   res_fail_end, v.exp_fail);
`ifdef BIST_FAIL_LOG_EN
        checkOutput({tag, "_fail_addr"},  int'(fail_addr), v.exp_faddr);
        checkOutput({tag, "_fail_exp"},   int'(fail_exp),  v.exp_fexp);
        checkOutput({tag, "_fail_act"},   int'(fail_act),  v.exp_fact);
`endif
    endtask

    initial begin
        int errs;
        vec_t clean;

        n_cmp    = 0;
        n_bad    = 0;
        fault_en = 1'b0;
        start    = 1'b0;
        rst      = 1'b1;
        ram_dout = 4'h0;
        for (int i = 0; i < 16; i++)
            mem[i] = 4'($urandom_range(0, 15));

        // A run has 10*16 operation cycles plus one drain cycle.
        // The writes are w0 for E0 and one write per address in each of
        // E1 to E4, which gives 80. The reads are one per address in each
        // of E1 to E5, which also gives 80.
        // The fault is first seen by the r0 of E1 at address 5.
        vecs[0] = '{"clean",        1'b0, 1'b0, 161, 80, 80, 0, 0, 0, 0};
        vecs[1] = '{"stuck_a5b0",   1'b1, 1'b0, 161, 80, 80, 1, 5, 0, 1};
        vecs[2] = '{"clean_after",  1'b0, 1'b0, 161, 80, 80, 0, 0, 0, 0};
        vecs[3] = '{"stray_start",  1'b0, 1'b1, 161, 80, 80, 0, 0, 0, 0};
        clean   = vecs[0];

        // Reset state, held over several clock edges.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",     int'(busy),     0);
        checkOutput("rst_done",     int'(done),     0);
        checkOutput("rst_fail",     int'(fail),     0);
        checkOutput("rst_ram_we",   int'(ram_we),   0);
        checkOutput("rst_ram_oe",   int'(ram_oe),   0);
        checkOutput("rst_ram_addr", int'(ram_addr), 0);
        checkOutput("rst_ram_din",  int'(ram_din),  0);
`ifdef BIST_FAIL_LOG_EN
        checkOutput("rst_fail_addr", int'(fail_addr), 0);
`endif
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Table-driven runs. Entry 2 follows the faulty entry 1, so it also
        // checks that fail and done clear when the start is accepted.
        for (int i = 0; i < 4; i++) begin
            fault_en = vecs[i].fault;
            applyStimulus(vecs[i].extra_start);
            checkRun(vecs[i].name, vecs[i]);
            repeat (3) @(negedge clk);
        end

        // E3 starts after 16 + 32 + 32 = 80 operation cycles. It walks
        // down from 15, doing r0 and then w1 at each address.
        fault_en = 1'b0;
        applyStimulus(1'b0);
        errs = 0;
        for (int j = 0; j < 32; j++) begin
            if (int'(tr_addr[80 + j]) != 15 - j / 2)
                errs++;
            if (j % 2 == 0) begin
                if (!(tr_oe[80 + j] && !tr_we[80 + j]))
                    errs++;
            end else begin
                if (!(tr_we[80 + j] && !tr_oe[80 + j] && tr_din[80 + j] == 4'hF))
                    errs++;
            end
        end
        checkOutput("e3_order_errors", errs, 0);
        checkOutput("e3_first_addr",   int'(tr_addr[80]),  15);
        checkOutput("e3_last_addr",    int'(tr_addr[111]), 0);
        checkOutput("e4_first_addr",   int'(tr_addr[112]), 15);
        checkOutput("e0_first_we",     int'(tr_we[0]),     1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run. The outputs must drop before the
        // next clock edge arrives.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        checkOutput("midrun_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_busy",     int'(busy),     0);
        checkOutput("midrun_done",     int'(done),     0);
        checkOutput("midrun_fail",     int'(fail),     0);
        checkOutput("midrun_ram_we",   int'(ram_we),   0);
        checkOutput("midrun_ram_oe",   int'(ram_oe),   0);
        checkOutput("midrun_ram_addr", int'(ram_addr), 0);
        checkOutput("midrun_ram_din",  int'(ram_din),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0);
        checkRun("after_rst", clean);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
